ext_reg_slv: RTL and testbench
==============================

# ext_reg_slv

Register-bank responder on the external side of the slave FSM's request/ack handshake. It accepts one request at a time (req_vld/req_rdy) and performs a write or read on an internal bank of REG_NUM words after a programmable access latency. It returns completion through ack_vld/ack_rdy, holding read data until the acknowledge is taken. It stands in for a real external register block behind the slave FSM, in both the design and the bench.

## Interface
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 32, data width; a power of two, at least 8
- BASE_ADDR, 0, byte address of word 0; aligned to DATA_WIDTH/8
- REG_NUM, 16, number of words in the bank; at least 1
- ACK_LATENCY, 2, idle cycles between request acceptance and entry to ACK; 0 to 15

- clk  in  1  clock; all logic is on the rising edge
- rstn  in  1  reset, asynchronous, active-low
- sync_reset  in  1  synchronous clear; highest priority
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- addr  in  ADDR_WIDTH  byte address
- wr_en  in  1  write request
- rd_en  in  1  read request
- wr_data  in  DATA_WIDTH  write data
- ack_vld  out  1  completion valid
- ack_rdy  in  1  completion accepted
- rd_data  out  DATA_WIDTH  read data; valid only while ack_vld=1

## Operation
- States:
  - IDLE: req_rdy=1.
  - WAIT: latency counter running; req_rdy=0, ack_vld=0.
  - ACK: ack_vld=1, req_rdy=0.
- Accept: a request is accepted in a cycle where state=IDLE and req_vld=1. addr, wr_en, rd_en and wr_data are sampled at that edge.
- After accept:
  - ACK_LATENCY>0: go to WAIT with the counter loaded to ACK_LATENCY-1.
  - ACK_LATENCY=0: go directly to ACK.
- WAIT: decrement the counter each cycle; go to ACK on the cycle after the counter reads 0.
- ACK: stay in ACK while ack_rdy=0. When ack_rdy=1, return to IDLE on the next edge.
- Decode:
  - Word index = (addr-BASE_ADDR) >> log2(DATA_WIDTH/8).
  - The address is mapped only if addr>=BASE_ADDR, index<REG_NUM, and the low log2(DATA_WIDTH/8) address bits are 0.
- Write (wr_en=1): if mapped, the bank word is updated at the accept edge. Unmapped writes are dropped. The ack is still returned.
- Read (rd_en=1, wr_en=0): rd_data is captured on entry to ACK. It is the bank word if mapped, otherwise 0. It is held stable through ACK.
- wr_en=1 and rd_en=1 together: perform the write; rd_data returns the newly written value if mapped, 0 if not.
- wr_en=0 and rd_en=0: no bank access; ack is returned with rd_data=0.
- rd_data is 0 whenever ack_vld=0.
- sync_reset=1, any state:
  - Next state is IDLE.
  - All bank words, the counter and the rd_data register clear to 0.
  - Any in-flight transaction is dropped with no ack.
  - A request presented in the same cycle is not accepted, and its write is not performed.
- Reset (rstn=0): same clear as sync_reset, applied asynchronously.
- Reset values: req_rdy=1, ack_vld=0, rd_data=0, every bank word 0.

## Timing
- Accept edge at cycle T → ack_vld first high in cycle T+1+ACK_LATENCY.
- With ack_rdy=1 on the first ack cycle: req_rdy is high again in cycle T+2+ACK_LATENCY. Throughput is one transaction per ACK_LATENCY+2 cycles.
- req_rdy, ack_vld and rd_data are driven from registers only. There is no combinational path from any input to any output.
- req_vld while req_rdy=0: ignored. The requester must hold the request until it is accepted.
- ack_rdy high in IDLE or WAIT: no effect.
- Back-to-back: a new request may be accepted in the first IDLE cycle after ACK.

## Test plan
- ACK_LATENCY=2: write addr=BASE+0x8, data 0xA5A5_0001, accepted at T → ack_vld at T+3 with rd_data=0; a following read of BASE+0x8 → rd_data=0xA5A5_0001 with ack_vld.
- Read with ack_rdy held 0 for 5 cycles → ack_vld and rd_data stable for 5 cycles; ack_rdy=1 → IDLE and req_rdy=1 on the next cycle.
- Unmapped and misaligned: write 0xFFFF_FFFF to BASE+REG_NUM*4 and to BASE+0x2, then read every word → all words still at their prior values, both acks returned, reads of the unmapped addresses → 0.
- ACK_LATENCY=0: accepted at T → ack_vld at T+1; with ack_rdy tied 1, req_rdy toggles 1,0,1 across back-to-back transactions.
- sync_reset asserted during WAIT after a write of 0x1234 → no ack, state IDLE, req_rdy=1 on the next cycle; a read of that address → 0.
- rstn pulsed low mid-ACK → ack_vld=0, rd_data=0, req_rdy=1 immediately while rstn=0.

Source files
------------

// File: rtl/ext_reg_slv.sv
// Register-bank responder behind a request/ack handshake: one transaction at a time,
// write or read of a REG_NUM-word bank, completion returned after ACK_LATENCY idle cycles.
module ext_reg_slv #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    REG_NUM     = 16,
    parameter int                    ACK_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sync_reset,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ack_vld,
    input  logic                  ack_rdy,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [3:0] LAT_LOAD = 4'((ACK_LATENCY > 0) ? ACK_LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt;
    logic [DATA_WIDTH-1:0]   bank [REG_NUM];
    logic [DATA_WIDTH-1:0]   rd_hold;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [IDX_W-1:0]        idx;
    logic                    mapped;
    logic [DATA_WIDTH-1:0]   rd_val;

    assign accept   = (state == IDLE) && req_vld && !sync_reset;
    assign offset   = addr - BASE_ADDR;
    assign word_idx = offset >> LSB;
    assign idx      = word_idx[IDX_W-1:0];
    assign mapped   = (addr >= BASE_ADDR) && (word_idx < ADDR_WIDTH'(REG_NUM)) &&
                      ((addr & LOW_MASK) == '0);

    // A combined write+read returns the data being written, since the bank updates on the same edge.
    always_comb begin
        rd_val = '0;
        if (rd_en && mapped) begin
            rd_val = wr_en ? wr_data : bank[idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (sync_reset) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (req_vld) state_nxt = (ACK_LATENCY == 0) ? ACK : WAIT;
                WAIT:    if (cnt == 4'd0) state_nxt = ACK;
                ACK:     if (ack_rdy) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // rd_hold parks the read value during WAIT so rd_data stays 0 until ACK is entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            rd_hold <= '0;
            rd_q    <= '0;
            for (int i = 0; i < REG_NUM; i++) bank[i] <= '0;
        end else if (sync_reset) begin
            cnt     <= '0;
            rd_hold <= '0;
            rd_q    <= '0;
            for (int i = 0; i < REG_NUM; i++) bank[i] <= '0;
        end else if (accept) begin
            cnt <= LAT_LOAD;
            if (wr_en && mapped) bank[idx] <= wr_data;
            if (ACK_LATENCY == 0) rd_q <= rd_val;
            else                  rd_hold <= rd_val;
        end else if (state == WAIT) begin
            if (cnt != 4'd0) cnt  <= cnt - 4'd1;
            else             rd_q <= rd_hold;
        end else if ((state == ACK) && ack_rdy) begin
            rd_q <= '0;
        end
    end

    assign req_rdy = (state == IDLE);
    assign ack_vld = (state == ACK);
    assign rd_data = rd_q;

endmodule

// File: tb/tb_ext_reg_slv.sv
// Scoreboard bench for ext_reg_slv: randomized traffic on a latency-2 instance checked
// against an array model, plus a latency-0 instance exercised back-to-back.
module tb_ext_reg_slv;

    localparam logic [63:0] BASE = 64'h100;
    localparam int          LAT  = 2;

    logic        clk = 0;
    logic        rstn = 0;
    logic        sync_reset = 0;
    logic        req_vld = 0;
    logic        req_rdy;
    logic [63:0] addr = '0;
    logic        wr_en = 0;
    logic        rd_en = 0;
    logic [31:0] wr_data = '0;
    logic        ack_vld;
    logic        ack_rdy = 0;
    logic [31:0] rd_data;

    logic        b_req_vld = 0;
    logic        b_req_rdy;
    logic [63:0] b_addr = '0;
    logic        b_wr_en = 0;
    logic        b_rd_en = 0;
    logic [31:0] b_wr_data = '0;
    logic        b_ack_vld;
    logic        b_ack_rdy = 1;
    logic        b_sync_reset = 0;
    logic [31:0] b_rd_data;

    ext_reg_slv #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .BASE_ADDR(BASE), .REG_NUM(16),
                  .ACK_LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn), .sync_reset(sync_reset), .req_vld(req_vld),
        .req_rdy(req_rdy), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
        .ack_vld(ack_vld), .ack_rdy(ack_rdy), .rd_data(rd_data));

    ext_reg_slv #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .BASE_ADDR(64'h0), .REG_NUM(16),
                  .ACK_LATENCY(0)) dut0 (
        .clk(clk), .rstn(rstn), .sync_reset(b_sync_reset), .req_vld(b_req_vld),
        .req_rdy(b_req_rdy), .addr(b_addr), .wr_en(b_wr_en), .rd_en(b_rd_en),
        .wr_data(b_wr_data), .ack_vld(b_ack_vld), .ack_rdy(b_ack_rdy), .rd_data(b_rd_data));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: the bank as a plain array, decoded straight from the address rules.
    logic [31:0] mbank [16];

    function automatic bit is_mapped(input logic [63:0] a);
        logic [63:0] wi;
        wi = (a - BASE) / 4;
        return (a >= BASE) && (wi < 16) && (a % 4 == 0);
    endfunction

    typedef struct {
        logic [31:0] data;
        int          exp_cyc;
    } exp_t;

    exp_t q[$];
    bit   front_seen = 0;
    bit   mon_en = 0;
    int   hold = 0;

    always @(posedge clk) begin
        #1;
        if (hold > 0) begin
            ack_rdy = 0;
            hold--;
        end else begin
            ack_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rstn && mon_en) begin
            chk("req_rdy", {63'd0, req_rdy}, {63'd0, q.size() == 0});
            if (q.size() == 0) begin
                chk("idle_ack_vld", {63'd0, ack_vld}, 64'd0);
                chk("idle_rd_data", {32'd0, rd_data}, 64'd0);
            end else if (!ack_vld) begin
                chk("wait_rd_data", {32'd0, rd_data}, 64'd0);
                if (front_seen || cyc >= q[0].exp_cyc) begin
                    total++;
                    bad++;
                    $display("FAIL ack_missing: ack_vld=0 at cycle %0d, required high from %0d",
                             cyc, q[0].exp_cyc);
                    void'(q.pop_front());
                    front_seen = 0;
                end
            end else begin
                if (!front_seen) begin
                    chk("ack_latency", 64'(cyc), 64'(q[0].exp_cyc));
                    front_seen = 1;
                end
                chk("ack_rd_data", {32'd0, rd_data}, {32'd0, q[0].data});
                if (ack_rdy) begin
                    void'(q.pop_front());
                    front_seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [63:0] a, input bit w, input bit r, input logic [31:0] d);
        int          n;
        logic [31:0] e;
        logic [63:0] wi;
        @(negedge clk);
        addr = a; wr_en = w; rd_en = r; wr_data = d; req_vld = 1;
        n = 0;
        while (!req_rdy) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL req_timeout: req_rdy=0 for %0d cycles, required 1", n);
                $fatal(1);
            end
        end
        wi = (a - BASE) / 4;
        e  = '0;
        if (r && is_mapped(a)) e = w ? d : mbank[wi[3:0]];
        if (w && is_mapped(a)) mbank[wi[3:0]] = d;
        @(posedge clk);
        #1;
        req_vld = 0;
        q.push_back('{data: e, exp_cyc: cyc + LAT});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic flush_model();
        q.delete();
        front_seen = 0;
        for (int i = 0; i < 16; i++) mbank[i] = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [63:0] ta [6];
    bit          tw [6];
    bit          tr [6];
    logic [31:0] td [6];
    logic [31:0] te [6];

    initial begin
        logic [63:0] a;
        logic [31:0] d0, d1;
        int          n;

        for (int i = 0; i < 16; i++) mbank[i] = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;

        @(negedge clk);
        chk("rst_req_rdy", {63'd0, req_rdy}, 64'd1);
        chk("rst_ack_vld", {63'd0, ack_vld}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);

        // Latency-0 instance: req_vld held high, ack_rdy tied high.
        d0 = $urandom; d1 = $urandom;
        ta = '{64'h0, 64'h4, 64'h4, 64'h0, 64'h0, 64'h2};
        tw = '{1, 1, 0, 0, 0, 0};
        tr = '{1, 0, 1, 1, 0, 1};
        td = '{d0, d1, $urandom, $urandom, $urandom, $urandom};
        te = '{d0, 32'h0, d1, d0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            chk("l0_idle_req_rdy", {63'd0, b_req_rdy}, 64'd1);
            chk("l0_idle_ack_vld", {63'd0, b_ack_vld}, 64'd0);
            chk("l0_idle_rd_data", {32'd0, b_rd_data}, 64'd0);
            b_addr = ta[i]; b_wr_en = tw[i]; b_rd_en = tr[i]; b_wr_data = td[i]; b_req_vld = 1;
            @(negedge clk);
            chk("l0_ack_vld", {63'd0, b_ack_vld}, 64'd1);
            chk("l0_ack_req_rdy", {63'd0, b_req_rdy}, 64'd0);
            chk("l0_rd_data", {32'd0, b_rd_data}, {32'd0, te[i]});
            @(negedge clk);
        end
        b_req_vld = 0;
        chk("l0_end_req_rdy", {63'd0, b_req_rdy}, 64'd1);

        mon_en = 1;
        for (int i = 0; i < 16; i++) issue(BASE + 64'(i * 4), 0, 1, '0);

        issue(BASE + 64'h8, 1, 0, 32'hA5A5_0001);
        issue(BASE + 64'h8, 0, 1, '0);

        hold = 10;
        issue(BASE + 64'h8, 0, 1, '0);
        drain();

        for (int i = 0; i < 16; i++) issue(BASE + 64'(i * 4), 1, 0, $urandom);
        issue(BASE + 64'd64, 1, 0, 32'hFFFF_FFFF);
        issue(BASE + 64'h2, 1, 0, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) issue(BASE + 64'(i * 4), 0, 1, '0);
        issue(BASE + 64'd64, 0, 1, '0);
        issue(BASE + 64'h2, 0, 1, '0);
        issue(BASE - 64'd4, 0, 1, '0);

        for (int k = 0; k < 60; k++) begin
            a = BASE - 64'd8 + 64'(4 * $urandom_range(0, 19));
            if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 3));
            issue(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        issue(BASE + 64'h10, 1, 0, 32'h1234);
        sync_reset = 1;
        @(posedge clk);
        #1 sync_reset = 0;
        flush_model();
        @(negedge clk);
        chk("srst_req_rdy", {63'd0, req_rdy}, 64'd1);
        chk("srst_ack_vld", {63'd0, ack_vld}, 64'd0);
        issue(BASE + 64'h10, 0, 1, '0);
        drain();

        issue(BASE + 64'h20, 1, 0, 32'hCAFE_F00D);
        hold = 20;
        issue(BASE + 64'h20, 0, 1, '0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_vld && n < 20);
        chk("pre_rstn_ack_vld", {63'd0, ack_vld}, 64'd1);
        #2 rstn = 0;
        flush_model();
        #1;
        chk("rstn_ack_vld", {63'd0, ack_vld}, 64'd0);
        chk("rstn_rd_data", {32'd0, rd_data}, 64'd0);
        chk("rstn_req_rdy", {63'd0, req_rdy}, 64'd1);
        @(posedge clk);
        #1 rstn = 1;
        hold = 0;
        issue(BASE + 64'h20, 0, 1, '0);
        drain();

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
